// File: rtl/core_ctrl_fsm.sv
// Core control state machine: sequences mul/div waits, WFI sleep, interrupt
// trap entry and mret return, and owns mstatus.MIE/MPIE.
module core_ctrl_fsm #(
  parameter int XLEN     = 32,
  parameter int CAUSE_I0 = 11,
  parameter int CAUSE_I1 = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic            dec_stall,
  input  logic            is_muldiv,
  input  logic            is_wfi,
  input  logic            is_mret,
  input  logic            dec_intr_en,
  input  logic            int0,
  input  logic            int1,
  input  logic            mul_rdy,
  input  logic            div_rdy,
  input  logic            csr_mie_we,
  input  logic            csr_mie_wd,
  output logic [2:0]      curr_state,
  output logic            muldiv_act,
  output logic            mstatus_we,
  output logic            mepc_we,
  output logic            mcause_we,
  output logic [XLEN-1:0] mcause_val,
  output logic [1:0]      pc_sel,
  output logic            flush,
  output logic            mie,
  output logic            mpie
);

  typedef enum logic [2:0] {
    ST_INST          = 3'd0,
    ST_MULDIV        = 3'd1,
    ST_TRAP_MSTATUS  = 3'd2,
    ST_TRAP_MEPC_SET = 3'd3,
    ST_TRAP_MTVEC    = 3'd4,
    ST_TRAP_MEPC_RET = 3'd5,
    ST_TRAP_INT      = 3'd6,
    ST_SLEEP         = 3'd7
  } state_t;

  localparam int CW = XLEN - 1;
  localparam logic [CW-1:0] C_I0 = CW'(CAUSE_I0);
  localparam logic [CW-1:0] C_I1 = CW'(CAUSE_I1);

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_MTVEC = 2'b01;
  localparam logic [1:0] PC_MEPC  = 2'b10;

  state_t        r_state;
  state_t        w_next;
  logic          r_mie;
  logic          r_mpie;
  logic [CW-1:0] r_cause;
  logic [CW-1:0] w_cause_sel;
  logic          w_latch_cause;
  logic          w_issue;
  logic          w_any_int;

  assign w_issue   = inst_valid & ~dec_stall;
  assign w_any_int = int0 | int1;

  // int0 has priority; with neither line high the previous cause is kept.
  assign w_cause_sel = int0 ? C_I0 : (int1 ? C_I1 : r_cause);

  always_comb begin
    w_next        = r_state;
    w_latch_cause = 1'b0;
    muldiv_act    = 1'b0;
    mstatus_we    = 1'b0;
    mepc_we       = 1'b0;
    mcause_we     = 1'b0;
    pc_sel        = PC_SEQ;
    flush         = 1'b0;
    case (r_state)
      ST_INST: begin
        if (dec_intr_en && r_mie) begin
          w_next        = ST_TRAP_MSTATUS;
          w_latch_cause = 1'b1;
        end else if (w_issue && is_mret) begin
          w_next = ST_TRAP_MEPC_RET;
        end else if (w_issue && is_muldiv) begin
          w_next = ST_MULDIV;
        end else if (w_issue && is_wfi) begin
          w_next = ST_SLEEP;
        end
      end
      ST_MULDIV: begin
        muldiv_act = 1'b1;
        if (mul_rdy || div_rdy) begin
          w_next = ST_INST;
        end
      end
      ST_TRAP_MSTATUS: begin
        mstatus_we = 1'b1;
        w_next     = ST_TRAP_MEPC_SET;
      end
      ST_TRAP_MEPC_SET: begin
        mepc_we = 1'b1;
        w_next  = ST_TRAP_MTVEC;
      end
      ST_TRAP_MTVEC: begin
        pc_sel = PC_MTVEC;
        flush  = 1'b1;
        w_next = ST_TRAP_INT;
      end
      ST_TRAP_INT: begin
        mcause_we = 1'b1;
        w_next    = ST_INST;
      end
      ST_TRAP_MEPC_RET: begin
        pc_sel     = PC_MEPC;
        flush      = 1'b1;
        mstatus_we = 1'b1;
        w_next     = ST_INST;
      end
      ST_SLEEP: begin
        // A wake with interrupts disabled simply resumes after the WFI.
        if (w_any_int) begin
          if (r_mie) begin
            w_next        = ST_TRAP_MSTATUS;
            w_latch_cause = 1'b1;
          end else begin
            w_next = ST_INST;
          end
        end
      end
      default: w_next = ST_INST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INST;
      r_mie   <= 1'b0;
      r_mpie  <= 1'b0;
      r_cause <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch_cause) begin
        r_cause <= w_cause_sel;
      end
      // CSR writes to MIE only land in INST, so trap/mret updates always win.
      case (r_state)
        ST_TRAP_MSTATUS: begin
          r_mpie <= r_mie;
          r_mie  <= 1'b0;
        end
        ST_TRAP_MEPC_RET: begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
        end
        ST_INST: begin
          if (csr_mie_we) begin
            r_mie <= csr_mie_wd;
          end
        end
        default: ;
      endcase
    end
  end

  assign curr_state = r_state;
  assign mie        = r_mie;
  assign mpie       = r_mpie;
  assign mcause_val = mcause_we ? {1'b1, r_cause} : '0;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Testbench for core_ctrl_fsm: directed scenario tasks plus a randomized run
// checked against a phase-queue reference model.
module tb_core_ctrl_fsm;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            inst_valid, dec_stall, is_muldiv, is_wfi, is_mret;
  logic            dec_intr_en, int0, int1, mul_rdy, div_rdy;
  logic            csr_mie_we, csr_mie_wd;
  logic [2:0]      curr_state;
  logic            muldiv_act, mstatus_we, mepc_we, mcause_we;
  logic [XLEN-1:0] mcause_val;
  logic [1:0]      pc_sel;
  logic            flush, mie, mpie;

  int tests_run = 0;
  int tests_failed = 0;

  core_ctrl_fsm #(.XLEN(XLEN), .CAUSE_I0(11), .CAUSE_I1(7)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .dec_stall(dec_stall),
    .is_muldiv(is_muldiv), .is_wfi(is_wfi), .is_mret(is_mret),
    .dec_intr_en(dec_intr_en), .int0(int0), .int1(int1),
    .mul_rdy(mul_rdy), .div_rdy(div_rdy),
    .csr_mie_we(csr_mie_we), .csr_mie_wd(csr_mie_wd),
    .curr_state(curr_state), .muldiv_act(muldiv_act), .mstatus_we(mstatus_we),
    .mepc_we(mepc_we), .mcause_we(mcause_we), .mcause_val(mcause_val),
    .pc_sel(pc_sel), .flush(flush), .mie(mie), .mpie(mpie)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {muldiv_act, mstatus_we, mepc_we, mcause_we, pc_sel[1:0], flush}
  wire [6:0] strb = {muldiv_act, mstatus_we, mepc_we, mcause_we, pc_sel, flush};

  function automatic logic [6:0] exp_strb(input int st);
    case (st)
      1:       return 7'b1000000;
      2:       return 7'b0100000;
      3:       return 7'b0010000;
      4:       return 7'b0000011;
      5:       return 7'b0100101;
      6:       return 7'b0001000;
      default: return 7'b0000000;
    endcase
  endfunction

  // driver tasks
  task automatic clear_inputs();
    inst_valid = 0; dec_stall = 0; is_muldiv = 0; is_wfi = 0; is_mret = 0;
    dec_intr_en = 0; int0 = 0; int1 = 0; mul_rdy = 0; div_rdy = 0;
    csr_mie_we = 0; csr_mie_wd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic set_mie(input logic v);
    csr_mie_we = 1; csr_mie_wd = v;
    tick();
    csr_mie_we = 0; csr_mie_wd = 0;
  endtask

  task automatic issue(input logic m, input logic w, input logic r);
    inst_valid = 1; is_muldiv = m; is_wfi = w; is_mret = r;
    tick();
    inst_valid = 0; is_muldiv = 0; is_wfi = 0; is_mret = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if ({curr_state, mie, mpie, strb, mcause_val} !== {3'd0, 1'b0, 1'b0, 7'd0, 32'd0}) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d state=%0d mie=%b mpie=%b strb=%b mcause=%h required state=0 all zero",
                 i, curr_state, mie, mpie, strb, mcause_val);
      end
      tick();
    end
  endtask

  task automatic test_muldiv();
    int n;
    n = $urandom_range(1, 5);
    issue(1, 0, 0);
    for (int k = 0; k < n; k++) begin
      mul_rdy = (k == n - 1);
      // a CSR write and an interrupt request must both be ignored here
      csr_mie_we = 1; csr_mie_wd = 1; dec_intr_en = 1;
      tests_run++;
      if (curr_state !== 3'd1 || muldiv_act !== 1'b1) begin
        tests_failed++;
        $display("FAIL muldiv_wait k=%0d state=%0d act=%b required state=1 act=1", k, curr_state, muldiv_act);
      end
      tick();
    end
    clear_inputs();
    tests_run++;
    if (curr_state !== 3'd0 || muldiv_act !== 1'b0 || mie !== 1'b0) begin
      tests_failed++;
      $display("FAIL muldiv_done state=%0d act=%b mie=%b required 0 0 0", curr_state, muldiv_act, mie);
    end
  endtask

  task automatic walk_trap(input string name, input logic [31:0] cause);
    int seq[4] = '{2, 3, 4, 6};
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (curr_state !== 3'(seq[k]) || strb !== exp_strb(seq[k])) begin
        tests_failed++;
        $display("FAIL %s_seq k=%0d state=%0d strb=%b required state=%0d strb=%b",
                 name, k, curr_state, strb, seq[k], exp_strb(seq[k]));
      end
      if (seq[k] == 6) begin
        tests_run++;
        if (mcause_val !== cause) begin
          tests_failed++;
          $display("FAIL %s_cause got=%h required=%h", name, mcause_val, cause);
        end
      end
      tick();
      dec_intr_en = 0;
    end
    tests_run++;
    if (curr_state !== 3'd0 || mie !== 1'b0 || mpie !== 1'b1 || strb !== 7'd0) begin
      tests_failed++;
      $display("FAIL %s_return state=%0d mie=%b mpie=%b strb=%b required 0 0 1 0", name, curr_state, mie, mpie, strb);
    end
  endtask

  task automatic test_trap();
    do_reset();
    set_mie(1);
    int0 = 1; dec_intr_en = 1;
    tick();
    int0 = 0;
    walk_trap("trap_int0", 32'h8000000B);
  endtask

  task automatic test_both_ints();
    do_reset();
    set_mie(1);
    int0 = 1; int1 = 1; dec_intr_en = 1;
    tick();
    walk_trap("both_first", 32'h8000000B);
    dec_intr_en = 1;
    tick();
    tests_run++;
    if (curr_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL both_no_retrap state=%0d required=0", curr_state);
    end
    int0 = 0;
    set_mie(1);
    dec_intr_en = 1;
    tick();
    walk_trap("both_second", 32'h80000007);
    clear_inputs();
  endtask

  task automatic test_wfi_sleep();
    do_reset();
    issue(0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (curr_state !== 3'd7 || strb !== 7'd0) begin
        tests_failed++;
        $display("FAIL sleep_hold k=%0d state=%0d strb=%b required state=7 strb=0", k, curr_state, strb);
      end
      if (k == 4) int1 = 1;
      tick();
    end
    int1 = 0;
    tests_run++;
    if (curr_state !== 3'd0 || strb !== 7'd0 || mie !== 1'b0) begin
      tests_failed++;
      $display("FAIL sleep_wake state=%0d strb=%b mie=%b required 0 0 0", curr_state, strb, mie);
    end
    // same wake with interrupts enabled enters the trap sequence
    set_mie(1);
    issue(0, 1, 0);
    repeat ($urandom_range(1, 4)) tick();
    int0 = 1;
    tick();
    int0 = 0;
    walk_trap("sleep_trap", 32'h8000000B);
  endtask

  task automatic test_mret();
    // previous trap left mie=0, mpie=1
    issue(0, 0, 1);
    tests_run++;
    if (curr_state !== 3'd5 || pc_sel !== 2'b10 || flush !== 1'b1 || mstatus_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL mret_state state=%0d pc_sel=%b flush=%b mstatus_we=%b required 5 10 1 1",
               curr_state, pc_sel, flush, mstatus_we);
    end
    tick();
    tests_run++;
    if (curr_state !== 3'd0 || mie !== 1'b1 || mpie !== 1'b1 || strb !== 7'd0) begin
      tests_failed++;
      $display("FAIL mret_return state=%0d mie=%b mpie=%b strb=%b required 0 1 1 0", curr_state, mie, mpie, strb);
    end
    // mret with mpie=0 after reset restores mie=0
    do_reset();
    issue(0, 0, 1);
    tick();
    tests_run++;
    if (curr_state !== 3'd0 || mie !== 1'b0 || mpie !== 1'b1) begin
      tests_failed++;
      $display("FAIL mret_mpie0 state=%0d mie=%b mpie=%b required 0 0 1", curr_state, mie, mpie);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_mie(1);
    dec_intr_en = 1; int1 = 1;
    tick();
    dec_intr_en = 0; int1 = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    tests_run++;
    if (curr_state !== 3'd0 || strb !== 7'd0 || mie !== 1'b0 || mcause_val !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid state=%0d strb=%b mie=%b mcause=%h required all zero", curr_state, strb, mie, mcause_val);
    end
  endtask

  // Randomized run: the model tracks a queue of upcoming trap/mret phases.
  task automatic test_random();
    int m_st;
    int m_plan[$];
    logic m_mie, m_mpie, old_mie;
    logic [31:0] m_cause;
    logic [31:0] exp_cause;
    do_reset();
    m_st = 0; m_mie = 0; m_mpie = 0; m_cause = 0; m_plan.delete();
    for (int c = 0; c < 3000; c++) begin
      exp_cause = (m_st == 6) ? (32'h80000000 | m_cause) : 32'd0;
      tests_run++;
      if (curr_state !== 3'(m_st) || mie !== m_mie || mpie !== m_mpie ||
          strb !== exp_strb(m_st) || mcause_val !== exp_cause) begin
        tests_failed++;
        $display("FAIL random c=%0d state=%0d mie=%b mpie=%b strb=%b mcause=%h required %0d %b %b %b %h",
                 c, curr_state, mie, mpie, strb, mcause_val, m_st, m_mie, m_mpie, exp_strb(m_st), exp_cause);
      end
      inst_valid = ($urandom_range(0, 3) != 0);
      dec_stall = ($urandom_range(0, 3) == 0);
      is_muldiv = ($urandom_range(0, 3) == 0);
      is_wfi = ($urandom_range(0, 5) == 0);
      is_mret = ($urandom_range(0, 7) == 0);
      dec_intr_en = ($urandom_range(0, 7) == 0);
      int0 = ($urandom_range(0, 5) == 0);
      int1 = ($urandom_range(0, 5) == 0);
      mul_rdy = ($urandom_range(0, 3) == 0);
      div_rdy = ($urandom_range(0, 5) == 0);
      csr_mie_we = ($urandom_range(0, 4) == 0);
      csr_mie_wd = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin
        m_st = 0; m_plan.delete(); m_mie = 0; m_mpie = 0; m_cause = 0;
      end else if (m_plan.size() > 0) begin
        if (m_st == 2) begin m_mpie = m_mie; m_mie = 0; end
        if (m_st == 5) begin m_mie = m_mpie; m_mpie = 1; end
        m_st = m_plan.pop_front();
      end else if (m_st == 1) begin
        if (mul_rdy || div_rdy) m_st = 0;
      end else if (m_st == 7) begin
        if (int0 || int1) begin
          if (m_mie) begin
            m_cause = int0 ? 32'd11 : 32'd7;
            m_st = 2; m_plan = '{3, 4, 6, 0};
          end else m_st = 0;
        end
      end else begin
        old_mie = m_mie;
        if (csr_mie_we) m_mie = csr_mie_wd;
        if (dec_intr_en && old_mie) begin
          m_cause = int0 ? 32'd11 : (int1 ? 32'd7 : m_cause);
          m_st = 2; m_plan = '{3, 4, 6, 0};
        end else if (inst_valid && !dec_stall) begin
          if (is_mret) begin m_st = 5; m_plan = '{0}; end
          else if (is_muldiv) m_st = 1;
          else if (is_wfi) m_st = 7;
        end
      end
      tick();
    end
    clear_inputs();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_muldiv();
    test_trap();
    test_both_ints();
    test_wfi_sleep();
    test_mret();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
